// File: rtl/fp_to_int.sv
// Iterative packed-FP to signed-integer converter, one bit shift per clock.
// Optional round-to-nearest-even build selected by defining FP2INT_ROUND_EN; default truncates.
module fp_to_int #(
    parameter int unsigned Mantissa_Size = 23,
    parameter int unsigned Exponent_Size = 8,
    parameter int unsigned Int_Width     = 32,
    parameter int unsigned N             = Mantissa_Size + Exponent_Size
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 enable_i,
    input  logic                 load_i,
    input  logic [N:0]           a_i,
    output logic [Int_Width-1:0] result_o,
    output logic                 done_o,
    output logic                 overflow_o
);

    localparam int unsigned Bias  = 2 ** (Exponent_Size - 1) - 1;
    localparam int unsigned MantW = Mantissa_Size + 1;
    localparam int unsigned WorkW = ((Int_Width > MantW) ? Int_Width : MantW) + 1;
    localparam int unsigned CntW  = $clog2(Mantissa_Size + Int_Width + 2);
    localparam int unsigned EW    = Exponent_Size + 1;
    localparam int          EMaxS = Int_Width - 1;
    localparam int          MantS = Mantissa_Size;

    localparam logic [Int_Width:0] MagLimNeg = {1'b0, 1'b1, {(Int_Width - 1){1'b0}}};
    localparam logic [Int_Width:0] MagLimPos = {2'b00, {(Int_Width - 1){1'b1}}};

    typedef enum logic [2:0] {StIdle, StLoad, StShift, StFinal, StDone} state_e;

    state_e                 state_q;
    logic [N:0]             a_q;
    logic [WorkW-1:0]       work_q;
    logic [CntW-1:0]        cnt_q;
    logic                   left_q;
    logic                   pend_ovf_q;
    logic [Int_Width-1:0]   result_q;
    logic                   done_q;
    logic                   overflow_q;
`ifdef FP2INT_ROUND_EN
    logic                   guard_q;
    logic                   sticky_q;
`endif

    logic                     sign;
    logic [Exponent_Size-1:0] exp_f;
    logic [Mantissa_Size-1:0] frac;
    logic signed [EW-1:0]     e_s;
    logic                     early_zero;
    logic                     early_ovf;
    logic                     go_left;
    logic [CntW-1:0]          shift_cnt;
    logic [Int_Width:0]       mag_r;
    logic [Int_Width:0]       mag_lim;
    logic                     sat;
    logic [Int_Width-1:0]     final_val;

    assign sign  = a_q[N];
    assign exp_f = a_q[N-1 -: Exponent_Size];
    assign frac  = a_q[Mantissa_Size-1:0];
    assign e_s   = $signed({1'b0, exp_f}) - $signed(EW'(Bias));

    // Classify the captured operand: early exit, shift direction and shift count.
    always_comb begin
        early_zero = 1'b0;
        early_ovf  = 1'b0;
        go_left    = 1'b0;
        shift_cnt  = '0;
        if (exp_f == '0) begin
            early_zero = 1'b1;
        end else if (&exp_f) begin
            early_ovf = 1'b1;
        end else if (e_s < 0) begin
`ifdef FP2INT_ROUND_EN
            if (e_s == -1) begin
                shift_cnt = CntW'(MantW);
            end else begin
                early_zero = 1'b1;
            end
`else
            early_zero = 1'b1;
`endif
        end else if (e_s > EMaxS) begin
            early_ovf = 1'b1;
        end else if ((e_s == EMaxS) && !(sign && (frac == '0))) begin
            early_ovf = 1'b1;
        end else if (e_s >= MantS) begin
            go_left   = 1'b1;
            shift_cnt = CntW'(e_s - MantS);
        end else begin
            shift_cnt = CntW'(MantS - e_s);
        end
    end

    // Magnitude (with optional rounding increment), range check and sign application.
    always_comb begin
        mag_r = {|work_q[WorkW-1:Int_Width], work_q[Int_Width-1:0]};
`ifdef FP2INT_ROUND_EN
        if (guard_q && (sticky_q || work_q[0])) begin
            mag_r = mag_r + 1'b1;
        end
`endif
        mag_lim = sign ? MagLimNeg : MagLimPos;
        sat     = pend_ovf_q || (mag_r > mag_lim);
        if (sat) begin
            final_val = sign ? {1'b1, {(Int_Width - 1){1'b0}}} : {1'b0, {(Int_Width - 1){1'b1}}};
        end else begin
            final_val = sign ? (~mag_r[Int_Width-1:0] + 1'b1) : mag_r[Int_Width-1:0];
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q    <= StIdle;
            a_q        <= '0;
            work_q     <= '0;
            cnt_q      <= '0;
            left_q     <= 1'b0;
            pend_ovf_q <= 1'b0;
            result_q   <= '0;
            done_q     <= 1'b0;
            overflow_q <= 1'b0;
`ifdef FP2INT_ROUND_EN
            guard_q    <= 1'b0;
            sticky_q   <= 1'b0;
`endif
        end else if (enable_i) begin
            if (load_i) begin
                a_q        <= a_i;
                state_q    <= StLoad;
                done_q     <= 1'b0;
                overflow_q <= 1'b0;
            end else begin
                unique case (state_q)
                    StIdle: begin
                        state_q <= StIdle;
                    end
                    StLoad: begin
                        work_q     <= (early_zero || early_ovf) ? '0 : WorkW'({1'b1, frac});
                        pend_ovf_q <= early_ovf;
                        left_q     <= go_left;
                        cnt_q      <= shift_cnt;
`ifdef FP2INT_ROUND_EN
                        guard_q    <= 1'b0;
                        sticky_q   <= 1'b0;
`endif
                        state_q    <= (shift_cnt == '0) ? StFinal : StShift;
                    end
                    StShift: begin
                        if (left_q) begin
                            work_q <= work_q << 1;
                        end else begin
                            work_q <= work_q >> 1;
`ifdef FP2INT_ROUND_EN
                            guard_q  <= work_q[0];
                            sticky_q <= sticky_q | guard_q;
`endif
                        end
                        cnt_q <= cnt_q - CntW'(1);
                        if (cnt_q == CntW'(1)) begin
                            state_q <= StFinal;
                        end
                    end
                    StFinal: begin
                        result_q   <= final_val;
                        overflow_q <= sat;
                        state_q    <= StDone;
                    end
                    StDone: begin
                        done_q <= 1'b1;
                    end
                    default: begin
                        state_q <= StIdle;
                    end
                endcase
            end
        end
    end

    assign result_o   = result_q;
    assign done_o     = done_q;
    assign overflow_o = overflow_q;

endmodule
